// File: rtl/sd_cmd_arbiter_pkg.sv
// ============================================================================
// Package  : sd_defines
// Brief    : Shared encodings and bit positions for the SD command arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package sd_defines;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_RESULT    = 3'd3,
      ST_CLEAR     = 3'd4
   } arb_state_e;

   // CMD_SET_REG layout: command index in [13:8], response type in [1:0]
   localparam int c_CMDSET_IDX_LSB = 8;
   localparam int c_CMDSET_IDX_W   = 6;
   localparam int c_CMDSET_RSP_LSB = 0;
   localparam int c_CMDSET_RSP_W   = 2;

   localparam int c_CICMD_BIT      = 0;
   localparam int c_CC_BIT         = 0;
   localparam int c_EI_BIT         = 15;
   localparam int c_ERR_ARB_TO_BIT = 4;

   localparam int c_CNT_W = 8;

   function automatic logic [c_CNT_W-1:0] sat_inc8(input logic [c_CNT_W-1:0] v);
      return (v == {c_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sd_cmd_arbiter_rr_arb2.sv
// ============================================================================
// Module   : sd_rr_arb2
// Brief    : Two-way arbiter (round-robin or fixed D-priority) with last grant
// Revision : 1.0
// ============================================================================
`default_nettype none

module sd_rr_arb2 #(
   parameter int PRIO_MODE = 0
) (
   input  logic CLK_PAD_IO,
   input  logic RST_PAD_I,
   input  logic req_h_i,
   input  logic req_d_i,
   input  logic take_i,
   output logic any_o,
   output logic gnt_o
);

   logic last_grant_q;
   logic last_grant_d;

   assign any_o = req_h_i | req_d_i;

   // gnt_o: 0 = H, 1 = D; on a tie round-robin picks the side not served last
   assign gnt_o = (PRIO_MODE == 1) ? req_d_i
                                   : (req_d_i & (~req_h_i | ~last_grant_q));

   always_comb begin
      last_grant_d = last_grant_q;
      if (take_i) begin
         last_grant_d = gnt_o;
      end
   end

   always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
      if (RST_PAD_I) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sd_cmd_arbiter.sv
// ============================================================================
// Module   : sd_cmd_arbiter
// Brief    : Shares the SD command master between host (H) and data engine (D)
// Revision : 1.0
// ============================================================================
`default_nettype none

module sd_cmd_arbiter
   import sd_defines::*;
#(
   parameter int PRIO_MODE = 0,
   parameter int ACCEPT_TO = 64,
   parameter int IDLE_TO   = 64
) (
   input  logic        CLK_PAD_IO,
   input  logic        RST_PAD_I,
   input  logic        h_req,
   input  logic [31:0] h_arg,
   input  logic [13:0] h_cmd,
   output logic        h_ack,
   output logic        h_done,
   output logic [31:0] h_resp,
   output logic [4:0]  h_err,
   input  logic        d_req,
   input  logic [31:0] d_arg,
   input  logic [13:0] d_cmd,
   output logic        d_ack,
   output logic        d_done,
   output logic [31:0] d_resp,
   output logic [4:0]  d_err,
   output logic        m_new_cmd,
   output logic [31:0] m_arg,
   output logic [13:0] m_cmd_set,
   input  logic [15:0] m_status,
   input  logic [15:0] m_normal_int,
   input  logic [4:0]  m_err_int,
   input  logic [31:0] m_resp,
   output logic        m_normal_int_rst,
   output logic        m_err_int_rst,
   output logic        busy
);

   localparam logic [c_CNT_W-1:0] c_ACCEPT_TO = c_CNT_W'(ACCEPT_TO);
   localparam logic [c_CNT_W-1:0] c_IDLE_TO   = c_CNT_W'(IDLE_TO);

   arb_state_e         state_q, state_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic               gnt_q, gnt_d;
   logic [31:0]        arg_q, arg_d;
   logic [13:0]        cmd_q, cmd_d;
   logic               new_cmd_q, new_cmd_d;
   logic               h_ack_q, h_ack_d;
   logic               d_ack_q, d_ack_d;
   logic [31:0]        h_resp_q, h_resp_d;
   logic [31:0]        d_resp_q, d_resp_d;
   logic [4:0]         h_err_q, h_err_d;
   logic [4:0]         d_err_q, d_err_d;

   logic               w_any;
   logic               w_gnt;
   logic               w_take;
   logic               w_res_wr;
   logic [31:0]        w_res_resp;
   logic [4:0]         w_res_err;
   logic [c_CNT_W-1:0] w_cnt_inc;
   logic               w_mbusy;
   logic               w_mfinish;
   logic               w_unused_bits;

   assign w_mbusy       = m_status[c_CICMD_BIT];
   assign w_mfinish     = m_normal_int[c_CC_BIT] | m_normal_int[c_EI_BIT];
   assign w_unused_bits = ^{m_status[15:1], m_normal_int[14:1], m_err_int[4]};

   sd_rr_arb2 #(
      .PRIO_MODE (PRIO_MODE)
   ) u_arb (
      .CLK_PAD_IO (CLK_PAD_IO),
      .RST_PAD_I  (RST_PAD_I),
      .req_h_i    (h_req),
      .req_d_i    (d_req),
      .take_i     (w_take),
      .any_o      (w_any),
      .gnt_o      (w_gnt)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      arg_d      = arg_q;
      cmd_d      = cmd_q;
      h_ack_d    = 1'b0;
      d_ack_d    = 1'b0;
      h_resp_d   = h_resp_q;
      d_resp_d   = d_resp_q;
      h_err_d    = h_err_q;
      d_err_d    = d_err_q;
      w_take     = 1'b0;
      w_res_wr   = 1'b0;
      w_res_resp = 32'h0;
      w_res_err  = 5'b0;
      w_cnt_inc  = sat_inc8(cnt_q);

      case (state_q)
         ST_IDLE: begin
            if (w_any) begin
               w_take  = 1'b1;
               gnt_d   = w_gnt;
               arg_d   = w_gnt ? d_arg : h_arg;
               cmd_d   = w_gnt ? d_cmd : h_cmd;
               h_ack_d = ~w_gnt;
               d_ack_d = w_gnt;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_mbusy) begin
               state_d = ST_WAIT_DONE;
            end else if (w_cnt_inc >= c_ACCEPT_TO) begin
               w_res_wr                    = 1'b1;
               w_res_err[c_ERR_ARB_TO_BIT] = 1'b1;
               state_d                     = ST_RESULT;
            end
         end
         ST_WAIT_DONE: begin
            // Completion with EI also set still counts as done; flags carry the error
            if (w_mfinish) begin
               w_res_wr   = 1'b1;
               w_res_resp = m_resp;
               w_res_err  = {1'b0, m_err_int[3:0]};
               state_d    = ST_RESULT;
            end
         end
         ST_RESULT: begin
            state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (!w_mbusy || (w_cnt_inc >= c_IDLE_TO)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (w_res_wr) begin
         if (gnt_q) begin
            d_resp_d = w_res_resp;
            d_err_d  = w_res_err;
         end else begin
            h_resp_d = w_res_resp;
            h_err_d  = w_res_err;
         end
      end

      cnt_d     = (state_d != state_q) ? '0 : w_cnt_inc;
      new_cmd_d = (state_q == ST_ISSUE) && (state_d == ST_ISSUE);
   end

   always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
      if (RST_PAD_I) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         gnt_q     <= 1'b0;
         arg_q     <= 32'h0;
         cmd_q     <= 14'h0;
         new_cmd_q <= 1'b0;
         h_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         h_resp_q  <= 32'h0;
         d_resp_q  <= 32'h0;
         h_err_q   <= 5'b0;
         d_err_q   <= 5'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         arg_q     <= arg_d;
         cmd_q     <= cmd_d;
         new_cmd_q <= new_cmd_d;
         h_ack_q   <= h_ack_d;
         d_ack_q   <= d_ack_d;
         h_resp_q  <= h_resp_d;
         d_resp_q  <= d_resp_d;
         h_err_q   <= h_err_d;
         d_err_q   <= d_err_d;
      end
   end

   assign h_ack            = h_ack_q;
   assign d_ack            = d_ack_q;
   assign h_done           = (state_q == ST_RESULT) & ~gnt_q;
   assign d_done           = (state_q == ST_RESULT) &  gnt_q;
   assign h_resp           = h_resp_q;
   assign d_resp           = d_resp_q;
   assign h_err            = h_err_q;
   assign d_err            = d_err_q;
   assign m_new_cmd        = new_cmd_q;
   assign m_arg            = arg_q;
   assign m_cmd_set        = cmd_q;
   assign m_normal_int_rst = (state_q == ST_RESULT);
   assign m_err_int_rst    = (state_q == ST_RESULT);
   assign busy             = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sd_cmd_arbiter.sv
// ============================================================================
// Module   : tb_sd_cmd_arbiter
// Brief    : Directed bench for sd_cmd_arbiter (round-robin and fixed-priority)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sd_cmd_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  h_req, d_req, h_ack, d_ack, h_done, d_done;
   logic [1:0]  m_new_cmd, m_nrst, m_erst, busy;
   logic [31:0] h_arg[2], d_arg[2], h_resp[2], d_resp[2], m_arg[2], m_resp[2];
   logic [13:0] h_cmd[2], d_cmd[2], m_cmd_set[2];
   logic [4:0]  h_err[2], d_err[2], m_err_int[2];
   logic [15:0] m_status[2], m_normal_int[2];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc;
   int hd_save;
   int h_done_cnt[2] = '{0, 0};
   int d_done_cnt[2] = '{0, 0};
   int h_ack_cnt[2]  = '{0, 0};

   logic [1:0]  mst_en, mst_ei;
   int          mst_dly[2], mst_ph[2], mst_cnt[2];
   logic [4:0]  mst_err[2];
   logic [31:0] mst_resp[2];

   sd_cmd_arbiter #(.PRIO_MODE(0), .ACCEPT_TO(64), .IDLE_TO(64)) dut0 (
      .CLK_PAD_IO(clk), .RST_PAD_I(rst),
      .h_req(h_req[0]), .h_arg(h_arg[0]), .h_cmd(h_cmd[0]), .h_ack(h_ack[0]),
      .h_done(h_done[0]), .h_resp(h_resp[0]), .h_err(h_err[0]),
      .d_req(d_req[0]), .d_arg(d_arg[0]), .d_cmd(d_cmd[0]), .d_ack(d_ack[0]),
      .d_done(d_done[0]), .d_resp(d_resp[0]), .d_err(d_err[0]),
      .m_new_cmd(m_new_cmd[0]), .m_arg(m_arg[0]), .m_cmd_set(m_cmd_set[0]),
      .m_status(m_status[0]), .m_normal_int(m_normal_int[0]), .m_err_int(m_err_int[0]),
      .m_resp(m_resp[0]), .m_normal_int_rst(m_nrst[0]), .m_err_int_rst(m_erst[0]),
      .busy(busy[0])
   );

   sd_cmd_arbiter #(.PRIO_MODE(1), .ACCEPT_TO(64), .IDLE_TO(64)) dut1 (
      .CLK_PAD_IO(clk), .RST_PAD_I(rst),
      .h_req(h_req[1]), .h_arg(h_arg[1]), .h_cmd(h_cmd[1]), .h_ack(h_ack[1]),
      .h_done(h_done[1]), .h_resp(h_resp[1]), .h_err(h_err[1]),
      .d_req(d_req[1]), .d_arg(d_arg[1]), .d_cmd(d_cmd[1]), .d_ack(d_ack[1]),
      .d_done(d_done[1]), .d_resp(d_resp[1]), .d_err(d_err[1]),
      .m_new_cmd(m_new_cmd[1]), .m_arg(m_arg[1]), .m_cmd_set(m_cmd_set[1]),
      .m_status(m_status[1]), .m_normal_int(m_normal_int[1]), .m_err_int(m_err_int[1]),
      .m_resp(m_resp[1]), .m_normal_int_rst(m_nrst[1]), .m_err_int_rst(m_erst[1]),
      .busy(busy[1])
   );

   // Command-master stand-in: raise busy on New_CMD, finish after mst_dly cycles
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_status[i] = 16'h0; m_normal_int[i] = 16'h0; m_err_int[i] = 5'b0;
            mst_ph[i] = 0;
         end else begin
            case (mst_ph[i])
               0: if (m_new_cmd[i] && mst_en[i]) begin
                     m_status[i] = 16'h0001; mst_cnt[i] = mst_dly[i]; mst_ph[i] = 1;
                  end
               1: if (mst_cnt[i] > 0) mst_cnt[i]--;
                  else begin
                     m_normal_int[i] = mst_ei[i] ? 16'h8001 : 16'h0001;
                     m_err_int[i]    = mst_ei[i] ? mst_err[i] : 5'b0;
                     m_resp[i]       = mst_resp[i];
                     mst_ph[i]       = 2;
                  end
               default: if (m_nrst[i]) begin
                     m_normal_int[i] = 16'h0; m_err_int[i] = 5'b0;
                     m_status[i] = 16'h0; mst_ph[i] = 0;
                  end
            endcase
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (h_done[i]) h_done_cnt[i]++;
         if (d_done[i]) d_done_cnt[i]++;
         if (h_ack[i])  h_ack_cnt[i]++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic sel(input int w, input int i);
      case (w)
         0:       return h_ack[i];
         1:       return d_ack[i];
         2:       return h_done[i];
         3:       return d_done[i];
         4:       return h_ack[i] | d_ack[i];
         default: return ~busy[i];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_for(input string tag, input int w, input int i, input int lim,
                           output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!sel(w, i) && cycles < lim);
      n_cmp++;
      assert (sel(w, i) === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: timed out after %0d cycles, observed 0 expected 1", tag, cycles);
      end
   endtask

   initial begin
      h_req = '0; d_req = '0;
      for (int i = 0; i < 2; i++) begin
         h_arg[i] = '0; d_arg[i] = '0; h_cmd[i] = '0; d_cmd[i] = '0;
         m_status[i] = '0; m_normal_int[i] = '0; m_err_int[i] = '0; m_resp[i] = '0;
         mst_dly[i] = 3; mst_err[i] = '0; mst_resp[i] = '0; mst_ph[i] = 0; mst_cnt[i] = 0;
      end
      mst_en = 2'b11; mst_ei = 2'b00;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_ack",    32'({h_ack, d_ack}), 0);
      chk("rst_done",   32'({h_done, d_done}), 0);
      chk("rst_newcmd", 32'(m_new_cmd), 0);
      chk("rst_marg",   m_arg[0], 0);
      rst = 1'b0;

      // Single host command
      h_arg[0] = 32'h0000_01AA; h_cmd[0] = 14'h0819; mst_resp[0] = 32'h0000_0120;
      h_req[0] = 1'b1;
      wait_for("t1_ack", 0, 0, 10, cyc);
      chk("t1_marg",    m_arg[0], 32'h0000_01AA);
      chk("t1_mcmd",    32'(m_cmd_set[0]), 32'h0819);
      chk("t1_newcmd0", 32'(m_new_cmd[0]), 0);
      h_req[0] = 1'b0;
      @(negedge clk);
      chk("t1_newcmd1", 32'(m_new_cmd[0]), 1);
      wait_for("t1_hdone", 2, 0, 30, cyc);
      chk("t1_hresp", h_resp[0], 32'h0000_0120);
      chk("t1_herr",  32'(h_err[0]), 0);
      chk("t1_ddone", 32'(d_done[0]), 0);
      chk("t1_irst",  32'({m_nrst[0], m_erst[0]}), 32'h3);
      @(negedge clk);
      chk("t1_hdone_pulse", 32'(h_done[0]), 0);
      wait_for("t1_idle", 5, 0, 30, cyc);

      // Round-robin with both held: D, H, D, H
      h_arg[0] = 32'hAAAA_0001; h_cmd[0] = 14'h0101;
      d_arg[0] = 32'hDDDD_0001; d_cmd[0] = 14'h0C0D;
      h_req[0] = 1'b1; d_req[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_for("t2_grant", 4, 0, 60, cyc);
         chk("t2_who_d", 32'(d_ack[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("t2_marg",  m_arg[0], (k % 2 == 0) ? 32'hDDDD_0001 : 32'hAAAA_0001);
      end
      h_req[0] = 1'b0; d_req[0] = 1'b0;
      wait_for("t2_hdone", 2, 0, 40, cyc);
      wait_for("t2_idle", 5, 0, 30, cyc);
      chk("t2_dcount", 32'(d_done_cnt[0]), 2);
      chk("t2_hcount", 32'(h_done_cnt[0]), 3);

      // Fixed priority: D always wins
      h_arg[1] = 32'h1111_0000; d_arg[1] = 32'h2222_0000;
      h_req[1] = 1'b1; d_req[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_for("t3_grant", 4, 1, 60, cyc);
         chk("t3_dack", 32'(d_ack[1]), 1);
         chk("t3_hack", 32'(h_ack[1]), 0);
      end
      h_req[1] = 1'b0; d_req[1] = 1'b0;
      wait_for("t3_idle", 5, 1, 40, cyc);
      chk("t3_h_never", 32'(h_ack_cnt[1]), 0);
      chk("t3_dcount",  32'(d_done_cnt[1]), 3);

      // Master never goes busy -> accept timeout
      mst_en[0] = 1'b0;
      h_arg[0] = 32'h0000_0005; h_req[0] = 1'b1;
      wait_for("t4_ack", 0, 0, 20, cyc);
      h_req[0] = 1'b0;
      wait_for("t4_hdone", 2, 0, 100, cyc);
      chk("t4_err",    32'(h_err[0]), 32'b10000);
      chk("t4_newcmd", 32'(m_new_cmd[0]), 0);
      chk("t4_lat",    32'(cyc >= 62 && cyc <= 66), 1);
      chk("t4_ddone",  32'(d_done[0]), 0);
      wait_for("t4_idle", 5, 0, 80, cyc);
      mst_en[0] = 1'b1;

      // CC+EI together with CRC error; err[4] from the master is not forwarded
      mst_ei[0] = 1'b1; mst_err[0] = 5'b10010; mst_resp[0] = 32'hBAD0_0001;
      d_arg[0] = 32'h0000_0C0C; d_req[0] = 1'b1;
      wait_for("t5_ack", 1, 0, 20, cyc);
      d_req[0] = 1'b0;
      wait_for("t5_ddone", 3, 0, 30, cyc);
      chk("t5_derr",  32'(d_err[0]), 32'b00010);
      chk("t5_dresp", d_resp[0], 32'hBAD0_0001);
      chk("t5_irst",  32'({m_nrst[0], m_erst[0]}), 32'h3);
      chk("t5_hhold", 32'(h_err[0]), 32'b10000);
      wait_for("t5_idle", 5, 0, 30, cyc);
      mst_ei[0] = 1'b0;

      // Reset while waiting for completion
      mst_dly[0] = 12; mst_resp[0] = 32'h0000_0777;
      h_arg[0] = 32'h0000_0777; h_req[0] = 1'b1;
      wait_for("t6_ack", 0, 0, 20, cyc);
      h_req[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_busy_before", 32'(busy[0]), 1);
      hd_save = h_done_cnt[0];
      #2 rst = 1'b1;
      #1;
      chk("t6_busy",   32'(busy[0]), 0);
      chk("t6_newcmd", 32'(m_new_cmd[0]), 0);
      chk("t6_marg",   m_arg[0], 0);
      chk("t6_herr",   32'(h_err[0]), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_nodone", 32'(h_done_cnt[0]), 32'(hd_save));
      mst_dly[0] = 3;
      h_req[0] = 1'b1;
      wait_for("t6_ack2", 0, 0, 20, cyc);
      h_req[0] = 1'b0;
      wait_for("t6_hdone", 2, 0, 30, cyc);
      chk("t6_hresp", h_resp[0], 32'h0000_0777);
      chk("t6_herr2", 32'(h_err[0]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
